uart_bus_master: RTL and testbench

- Register-bus initiator that drives the UART peripheral's register interface from the host side.
- After reset it programs the baud divisor and enable registers.
- It then drains a byte stream from an internal TX FIFO into the TX_DATA register, spaced by one frame time, and periodically polls RX_DATA to produce a received-byte stream.
- Sits between a streaming client (valid/ready) and the UART top's address/write_data/we/re/read_data port.

---
 rtl/uart_bus_master.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// Register-bus initiator for the UART peripheral: programs baud/enable, then paces TX bytes
// from a FIFO one frame apart and polls RX_DATA. Optional macro: UART_MASTER_RX_DEDUP_EN.
module uart_bus_master #(
    parameter int unsigned BAUD_DIV      = 868,
    parameter int unsigned FRAME_CYCLES  = 8680,
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        busy,
    output logic [1:0]  address,
    output logic [31:0] write_data,
    output logic        we,
    output logic        re,
    input  logic [7:0]  read_data
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned GapW  = $clog2(FRAME_CYCLES);
    localparam int unsigned PollW = $clog2(POLL_INTERVAL);

    localparam logic [2:0] StInitBaud = 3'd0;
    localparam logic [2:0] StInitEn   = 3'd1;
    localparam logic [2:0] StIdle     = 3'd2;
    localparam logic [2:0] StWrTx     = 3'd3;
    localparam logic [2:0] StRdReq    = 3'd4;
    localparam logic [2:0] StRdCap    = 3'd5;

    localparam logic [1:0] AddrBaud = 2'd0;
    localparam logic [1:0] AddrEn   = 2'd1;
    localparam logic [1:0] AddrTx   = 2'd2;
    localparam logic [1:0] AddrRx   = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic             pend_q, pend_d;
    logic [7:0]       prev_rx_q, prev_rx_d;
    logic [1:0]       address_q, address_d;
    logic [31:0]      write_data_q, write_data_d;
    logic             we_q, we_d;
    logic             re_q, re_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;

    logic       push;
    logic       pop;
    logic       poll_clr;
    logic       gap_load;
    logic       in_init;
    logic       fifo_empty;
    logic       poll_wrap;
    logic [7:0] head;

    assign push       = tx_valid && tx_ready_q;
    assign in_init    = (state_q == StInitBaud) || (state_q == StInitEn);
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign poll_wrap  = !in_init && (poll_q == PollW'(POLL_INTERVAL - 1));

    // Strobes are registered, so each decision here shows on the bus in the following cycle.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        prev_rx_d    = prev_rx_q;
        pop          = 1'b0;
        poll_clr     = 1'b0;
        gap_load     = 1'b0;
        case (state_q)
            StInitBaud: begin
                address_d    = AddrBaud;
                write_data_d = 32'(BAUD_DIV);
                we_d         = 1'b1;
                state_d      = StInitEn;
            end
            StInitEn: begin
                address_d    = AddrEn;
                write_data_d = 32'd1;
                we_d         = 1'b1;
                state_d      = StIdle;
            end
            StIdle: begin
                if (pend_q) begin
                    address_d = AddrRx;
                    re_d      = 1'b1;
                    poll_clr  = 1'b1;
                    state_d   = StRdReq;
                end else if (!fifo_empty && (gap_q == '0)) begin
                    address_d    = AddrTx;
                    write_data_d = {24'b0, head};
                    we_d         = 1'b1;
                    pop          = 1'b1;
                    gap_load     = 1'b1;
                    state_d      = StWrTx;
                end
            end
            StWrTx: begin
                state_d = StIdle;
            end
            StRdReq: begin
                // read_data becomes valid while in this state's successor
                state_d = StRdCap;
            end
            StRdCap: begin
                rx_byte_d = read_data;
`ifdef UART_MASTER_RX_DEDUP_EN
                rx_valid_d = (read_data != prev_rx_q);
`else
                rx_valid_d = 1'b1;
`endif
                prev_rx_d = read_data;
                state_d   = StIdle;
            end
            default: begin
                state_d = StInitBaud;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        if (gap_load) begin
            gap_d = GapW'(FRAME_CYCLES - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GapW'(1);
        end else begin
            gap_d = gap_q;
        end

        if (in_init || poll_wrap) begin
            poll_d = '0;
        end else begin
            poll_d = poll_q + PollW'(1);
        end

        // A wrap landing while a poll is still pending is simply absorbed.
        if (poll_clr) begin
            pend_d = 1'b0;
        end else if (poll_wrap) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        tx_ready_d = (count_d != CntW'(FIFO_DEPTH));
        busy_d     = in_init || !fifo_empty || (gap_q != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInitBaud;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            poll_q       <= '0;
            pend_q       <= 1'b0;
            prev_rx_q    <= 8'd0;
            address_q    <= 2'd0;
            write_data_q <= 32'd0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            poll_q       <= poll_d;
            pend_q       <= pend_d;
            prev_rx_q    <= prev_rx_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            we_q         <= we_d;
            re_q         <= re_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign we         = we_q;
    assign re         = re_q;

    we_re_exclusive: assert property (@(posedge clk) disable iff (rst) !(we_q && re_q));

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: a cycle model built from queues and counters,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_bus_master;

    localparam int unsigned BaudDiv      = 868;
    localparam int unsigned FrameCycles  = 20;
    localparam int unsigned PollInterval = 64;
    localparam int unsigned FifoDepth    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_byte = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic [1:0]  address;
    logic [31:0] write_data;
    logic        we;
    logic        re;
    logic [7:0]  read_data = 8'h55;

    always #5 clk = ~clk;

    uart_bus_master #(
        .BAUD_DIV     (BaudDiv),
        .FRAME_CYCLES (FrameCycles),
        .POLL_INTERVAL(PollInterval),
        .FIFO_DEPTH   (FifoDepth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .address   (address),
        .write_data(write_data),
        .we        (we),
        .re        (re),
        .read_data (read_data)
    );

    int errors = 0;
    int checks = 0;
    int since_rel = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t cycle=%0d: got %0h expected %0h", name, $time, since_rel,
                     act, exp);
        end
    endtask

    always @(posedge clk) since_rel <= rst ? 0 : since_rel + 1;

    // Model: expected outputs for the cycle after each edge.
    logic [7:0]  m_fifo[$];
    int          m_gap, m_poll, m_age, m_rd;
    bit          m_pend, m_wr, m_live = 1'b0;
    logic [7:0]  m_prev;
    logic [1:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_we, e_re, e_rxv, e_ready, e_busy;
    logic [7:0]  e_rx;

    always @(posedge clk) begin : model
        bit push, pop, clr, wrap;
        int gap_n;
        if (rst) begin
            m_fifo.delete();
            m_gap = 0; m_poll = 0; m_age = 0; m_rd = 0; m_pend = 0; m_wr = 0; m_prev = 8'd0;
            e_addr = 2'd0; e_wdata = 32'd0; e_we = 0; e_re = 0; e_rxv = 0; e_rx = 8'd0;
            e_ready = 0; e_busy = 1; m_live = 1;
        end else if (m_live) begin
            push = tx_valid && e_ready;
            pop = 0;
            clr = 0;
            e_busy = (m_age < 2) || (m_fifo.size() != 0) || (m_gap != 0);
            gap_n = (m_gap > 0) ? m_gap - 1 : 0;
            e_we = 0; e_re = 0; e_rxv = 0;
            if (m_age == 0) begin
                e_we = 1; e_addr = 2'd0; e_wdata = BaudDiv;
            end else if (m_age == 1) begin
                e_we = 1; e_addr = 2'd1; e_wdata = 32'd1;
            end else if (m_rd == 2) begin
                m_rd = 1;
            end else if (m_rd == 1) begin
                e_rx = read_data;
`ifdef UART_MASTER_RX_DEDUP_EN
                e_rxv = (read_data != m_prev);
`else
                e_rxv = 1;
`endif
                m_prev = read_data;
                m_rd = 0;
            end else if (m_wr) begin
                m_wr = 0;
            end else if (m_pend) begin
                e_re = 1; e_addr = 2'd3; clr = 1; m_rd = 2;
            end else if (m_fifo.size() > 0 && m_gap == 0) begin
                e_we = 1; e_addr = 2'd2; e_wdata = {24'h0, m_fifo[0]};
                pop = 1; gap_n = FrameCycles - 1; m_wr = 1;
            end
            wrap = (m_age >= 2) && (m_poll == PollInterval - 1);
            if (m_age >= 2) m_poll = wrap ? 0 : m_poll + 1;
            if (clr) m_pend = 0;
            else if (wrap) m_pend = 1;
            m_gap = gap_n;
            if (pop) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(tx_byte);
            e_ready = (m_fifo.size() < FifoDepth);
            if (m_age < 2) m_age++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("we", we, e_we);
            check("re", re, e_re);
            check("address", address, e_addr);
            check("write_data", write_data, e_wdata);
            check("rx_valid", rx_valid, e_rxv);
            check("rx_byte", rx_byte, e_rx);
            check("tx_ready", tx_ready, e_ready);
            check("busy", busy, e_busy);
            check("we_re_exclusive", we & re, 0);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic to_cycle(input int k);
        while (since_rel < k) @(negedge clk);
    endtask

    task automatic wait_tx(input int bound, output bit hit, output logic [31:0] data,
                           output int cyc);
        hit = 0; data = '0; cyc = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (we && address == 2'd2) begin
                hit = 1; data = write_data; cyc = since_rel;
            end
        end
    endtask

    initial begin
        bit          hit;
        logic [31:0] data;
        int          first, second, cyc, idx, stale;

        // Init sequence and two paced TX writes.
        reset_dut();
        @(negedge clk);
        check("init1_we", we, 1); check("init1_addr", address, 0);
        check("init1_data", write_data, 868);
        @(negedge clk);
        check("init2_we", we, 1); check("init2_addr", address, 1);
        check("init2_data", write_data, 1);
        @(negedge clk);
        check("init3_we", we, 0); check("init3_busy", busy, 0);
        check("init3_ready", tx_ready, 1);
        tx_valid = 1'b1; tx_byte = 8'hA5;
        @(negedge clk);
        tx_byte = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        check("a5_we", we, 1); check("a5_addr", address, 2);
        check("a5_data", write_data, 32'h0000_00A5);
        check("a5_latency", since_rel, 5);
        first = since_rel;
        wait_tx(100, hit, data, second);
        check("3c_seen", hit, 1);
        check("3c_data", data, 32'h0000_003C);
        check("3c_spacing", second - first, 20);
        cyc = 0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check("busy_fall", since_rel - second, 20);

        // Fill the FIFO behind an active gap.
        reset_dut();
        to_cycle(3);
        tx_valid = 1'b1; tx_byte = 8'hEE;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            tx_byte = 8'h10 + 8'(i);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("full_ready_low", tx_ready, 0);
        to_cycle(24);
        check("full_ready_still_low", tx_ready, 0);
        @(negedge clk);
        check("fill0_we", we, 1); check("fill0_data", write_data, 32'h10);
        check("ready_after_pop", tx_ready, 1);
        idx = 1;
        for (int i = 0; i < 800 && idx < 16; i++) begin
            @(negedge clk);
            if (we && address == 2'd2) begin
                check("fill_order", write_data, 32'h10 + 32'(idx));
                idx++;
            end
        end
        check("fill_all_written", idx, 16);

        // Polling, with a TX byte becoming due on the same IDLE cycle as the first poll.
        reset_dut();
        read_data = 8'h55;
        to_cycle(65);
        tx_valid = 1'b1; tx_byte = 8'h77;
        @(negedge clk);
        tx_valid = 1'b0;
        to_cycle(67);
        check("poll1_re", re, 1); check("poll1_addr", address, 3); check("poll1_we", we, 0);
        to_cycle(69);
        check("poll1_rxv", rx_valid, 1); check("poll1_rx", rx_byte, 8'h55);
        to_cycle(70);
        check("coll_we", we, 1); check("coll_addr", address, 2);
        check("coll_data", write_data, 32'h77);
        to_cycle(131);
        check("poll2_re", re, 1);
        to_cycle(133);
`ifdef UART_MASTER_RX_DEDUP_EN
        check("poll2_rxv", rx_valid, 0);
`else
        check("poll2_rxv", rx_valid, 1);
`endif
        to_cycle(190);
        read_data = 8'hC3;
        to_cycle(195);
        check("poll3_re", re, 1);
        to_cycle(197);
        check("poll3_rxv", rx_valid, 1); check("poll3_rx", rx_byte, 8'hC3);

        // Reset while bytes wait behind the gap.
        reset_dut();
        to_cycle(3);
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_byte = 8'hA1 + 8'(i);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        to_cycle(10);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", tx_ready, 0); check("mid_rst_we", we, 0);
        check("mid_rst_re", re, 0); check("mid_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("reinit1_we", we, 1); check("reinit1_data", write_data, 868);
        @(negedge clk);
        check("reinit2_addr", address, 1);
        stale = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (we && address == 2'd2) stale++;
        end
        check("no_stale_tx", stale, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
